bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 37 +++
 rtl/bus_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Two-master shared-bus interface: per-master request/strobe/data plus the shared bus.
// The timeout signal exists only when BUS_ARBITER_TIMEOUT_EN is defined.
interface bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0, req1;
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              rd0, rd1, wr0, wr1;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_read, bus_write;
    logic [DATA_W-1:0] bus_rdata;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [1:0]        owner;
`ifdef BUS_ARBITER_TIMEOUT_EN
    logic              timeout;
`endif

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, rd0, rd1, wr0, wr1, bus_rdata,
        input  gnt0, gnt1, bus_addr, bus_wdata, bus_read, bus_write, rdata0, rdata1, owner
`ifdef BUS_ARBITER_TIMEOUT_EN
        , input timeout
`endif
    );

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, rd0, rd1, wr0, wr1, bus_rdata,
        output gnt0, gnt1, bus_addr, bus_wdata, bus_read, bus_write, rdata0, rdata1, owner
`ifdef BUS_ARBITER_TIMEOUT_EN
        , output timeout
`endif
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (processor = 0, GPU = 1) with fair alternation and a turnaround cycle.
// Optional tenure watchdog enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic        clock,
    input logic        reset_n,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic [1:0]  owner_q, owner_d;
    logic        expired;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        expired = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        expired   = (state_q == OWN0 || state_q == OWN1) && (cnt_q + 16'd1 >= TO_LIM);
        cnt_d     = (state_q == OWN0 || state_q == OWN1) ? cnt_q + 16'd1 : 16'd0;
        timeout_d = expired;
`endif
        case (state_q)
            // TURN arbitrates exactly like IDLE so a waiting master is granted
            // right after the single turnaround cycle.
            IDLE, TURN: begin
                if (bus.req0 && (!bus.req1 || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0:    if (!bus.req0 || expired) state_d = TURN;
            OWN1:    if (!bus.req1 || expired) state_d = TURN;
            default: state_d = IDLE;
        endcase
        gnt0_d  = (state_d == OWN0);
        gnt1_d  = (state_d == OWN1);
        owner_d = {gnt1_d, gnt0_d};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            owner_q   <= 2'b00;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            owner_q   <= owner_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.owner = owner_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`endif

    // Bus mux keys off the grant flops, so reset clears it without a clock edge.
    always_comb begin
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.bus_read  = 1'b0;
        bus.bus_write = 1'b0;
        bus.rdata0    = '0;
        bus.rdata1    = '0;
        if (gnt0_q) begin
            bus.bus_addr  = bus.addr0;
            bus.bus_wdata = bus.wdata0;
            bus.bus_write = bus.wr0;
            bus.bus_read  = bus.rd0 & ~bus.wr0;
            bus.rdata0    = bus.bus_rdata;
        end else if (gnt1_q) begin
            bus.bus_addr  = bus.addr1;
            bus.bus_wdata = bus.wdata1;
            bus.bus_write = bus.wr1;
            bus.bus_read  = bus.rd1 & ~bus.wr1;
            bus.rdata1    = bus.bus_rdata;
        end
    end
endmodule
